counter_nbit: RTL and testbench

Parametrised general-purpose counter: WIDTH-bit register with up, down, rotate-left and rotate-right modes. Also provides synchronous set, parallel load, clock enable, programmable modulus, optional saturation, and terminal-count/wrap flags. Used as the common counting primitive for timers, sequencers and address generators across the design.

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_next.sv | 49 ++++
 rtl/counter_nbit.sv | 63 ++++++
 tb/tb_counter_nbit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the general-purpose counter primitive.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_ROTL = 2'b10,
    MODE_ROTR = 2'b11
  } counter_mode_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and wrap-event logic for one counting/rotate step.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int SATURATE  = 0
) (
  input  logic [WIDTH-1:0] count,
  input  counter_mode_t    mode,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_event
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  always_comb begin
    next_count = count;
    wrap_event = 1'b0;
    case (mode)
      MODE_UP: begin
        // Values above MAX_COUNT (from load or rotate) are treated as at the limit.
        if (count >= MAX_VAL) begin
          if (SATURATE == 0) begin
            next_count = '0;
            wrap_event = 1'b1;
          end
        end else begin
          next_count = count + ONE;
        end
      end
      MODE_DOWN: begin
        if (count == '0) begin
          if (SATURATE == 0) begin
            next_count = MAX_VAL;
            wrap_event = 1'b1;
          end
        end else begin
          next_count = count - ONE;
        end
      end
      MODE_ROTL: next_count = {count[WIDTH-2:0], count[WIDTH-1]};
      MODE_ROTR: next_count = {count[0], count[WIDTH-1:1]};
      default:   next_count = count;
    endcase
  end

endmodule

// File: rtl/counter_nbit.sv
// Parametrised up/down/rotate counter with set, load, enable, modulus,
// optional saturation, terminal-count and registered wrap pulse.
module counter_nbit
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  counter_mode_t    mode_e;
  logic [WIDTH-1:0] next_count;
  logic             wrap_event;

  assign mode_e = counter_mode_t'(mode);

  counter_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_next (
    .count      (count),
    .mode       (mode_e),
    .next_count (next_count),
    .wrap_event (wrap_event)
  );

  // Priority: set > load > enabled step > hold; wrap only survives an enabled step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (set) begin
      count <= MAX_VAL;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= next_count;
      wrap  <= wrap_event;
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign tc = en & (((mode_e == MODE_UP) & (count >= MAX_VAL)) |
                    ((mode_e == MODE_DOWN) & (count == '0)));

endmodule

// File: tb/tb_counter_nbit.sv
// Bench for counter_nbit: three instances (4-bit wrap, 4-bit saturate, 8-bit default)
// driven with shared stimulus, directed scenarios plus a randomized model comparison.
module tb_counter_nbit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, set = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] lv = 8'd0;

  logic [3:0] w_count, s_count;
  logic [7:0] d_count;
  logic       w_tc, s_tc, d_tc, w_wrap, s_wrap, d_wrap;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state: count and pending wrap flag per instance.
  int mw = 0, ms = 0, md = 0;
  bit mww = 0, mws = 0, mwd = 0;

  always #5 clk = ~clk;

  counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .set(set), .load(load), .load_val(lv[3:0]),
    .mode(mode), .count(w_count), .tc(w_tc), .wrap(w_wrap));

  counter_nbit #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .set(set), .load(load), .load_val(lv[3:0]),
    .mode(mode), .count(s_count), .tc(s_tc), .wrap(s_wrap));

  counter_nbit dut_d (
    .clk(clk), .reset(reset), .en(en), .set(set), .load(load), .load_val(lv),
    .mode(mode), .count(d_count), .tc(d_tc), .wrap(d_wrap));

  function automatic int model_next(int c, int w, int mx, bit sat, output bit wr);
    int m;
    m = 1 << w;
    wr = 1'b0;
    if (set) return mx;
    if (load) return int'(lv) % m;
    if (!en) return c;
    case (mode)
      2'd0: begin
        if (c < mx) return c + 1;
        if (sat) return c;
        wr = 1'b1;
        return 0;
      end
      2'd1: begin
        if (c > 0) return c - 1;
        if (sat) return 0;
        wr = 1'b1;
        return mx;
      end
      2'd2: return ((c * 2) % m) + (c / (m / 2));
      default: return ((c % 2) * (m / 2)) + (c / 2);
    endcase
  endfunction

  function automatic bit model_tc(int c, int mx);
    return en && ((mode == 2'd0 && c >= mx) || (mode == 2'd1 && c == 0));
  endfunction

  // One clock: advance the models on the rising edge, return at the falling edge.
  task automatic tick();
    bit wr;
    @(posedge clk);
    if (!reset) begin
      mw = 0; ms = 0; md = 0;
      mww = 0; mws = 0; mwd = 0;
    end else begin
      mw = model_next(mw, 4, 9, 1'b0, wr);   mww = wr;
      ms = model_next(ms, 4, 9, 1'b1, wr);   mws = wr;
      md = model_next(md, 8, 255, 1'b0, wr); mwd = wr;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (w_count !== 4'd0) $display("FAIL reset_count: count=%0d expected 0", w_count); else n_pass++;
    n_checks++; if (w_wrap !== 1'b0) $display("FAIL reset_wrap: wrap=%0b expected 0", w_wrap); else n_pass++;
    n_checks++; if (d_count !== 8'd0) $display("FAIL reset_count8: count=%0d expected 0", d_count); else n_pass++;
    en = 1'b1; mode = 2'd1; #1;
    n_checks++; if (w_tc !== 1'b1) $display("FAIL reset_tc_down: tc=%0b expected 1", w_tc); else n_pass++;
    mode = 2'd0; #1;
    n_checks++; if (w_tc !== 1'b0) $display("FAIL reset_tc_up: tc=%0b expected 0", w_tc); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    load = 1'b1; lv = 8'd5;
    tick();
    load = 1'b0; en = 1'b1; mode = 2'd0;
    n_checks++; if (w_count !== 4'd5) $display("FAIL mid_load: count=%0d expected 5", w_count); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (w_count !== 4'd0) $display("FAIL mid_reset_count: count=%0d expected 0", w_count); else n_pass++;
    n_checks++; if (d_count !== 8'd0) $display("FAIL mid_reset_count8: count=%0d expected 0", d_count); else n_pass++;
    n_checks++; if (w_wrap !== 1'b0) $display("FAIL mid_reset_wrap: wrap=%0b expected 0", w_wrap); else n_pass++;
    @(negedge clk);
    mw = 0; ms = 0; md = 0; mww = 0; mws = 0; mwd = 0;
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (w_count !== 4'(i)) $display("FAIL after_release: count=%0d expected %0d", w_count, i); else n_pass++;
    end
  endtask

  task automatic test_up_wrap();
    load = 1'b1; lv = 8'd8; en = 1'b1; mode = 2'd0;
    tick();
    load = 1'b0;
    tick();
    n_checks++; if (w_count !== 4'd9) $display("FAIL up_to_max: count=%0d expected 9", w_count); else n_pass++;
    n_checks++; if (w_tc !== 1'b1) $display("FAIL up_tc: tc=%0b expected 1", w_tc); else n_pass++;
    tick();
    n_checks++; if (w_count !== 4'd0) $display("FAIL up_wrap_count: count=%0d expected 0", w_count); else n_pass++;
    n_checks++; if (w_wrap !== 1'b1) $display("FAIL up_wrap_pulse: wrap=%0b expected 1", w_wrap); else n_pass++;
    n_checks++; if (s_count !== 4'd9) $display("FAIL up_sat_hold: count=%0d expected 9", s_count); else n_pass++;
    n_checks++; if (s_wrap !== 1'b0) $display("FAIL up_sat_wrap: wrap=%0b expected 0", s_wrap); else n_pass++;
    n_checks++; if (s_tc !== 1'b1) $display("FAIL up_sat_tc: tc=%0b expected 1", s_tc); else n_pass++;
    tick();
    n_checks++; if (w_count !== 4'd1) $display("FAIL up_after_wrap: count=%0d expected 1", w_count); else n_pass++;
    n_checks++; if (w_wrap !== 1'b0) $display("FAIL up_wrap_clear: wrap=%0b expected 0", w_wrap); else n_pass++;
  endtask

  task automatic test_down_sat();
    load = 1'b1; lv = 8'd1; mode = 2'd1;
    tick();
    load = 1'b0;
    tick();
    n_checks++; if (s_count !== 4'd0) $display("FAIL down_to_zero: count=%0d expected 0", s_count); else n_pass++;
    n_checks++; if (s_tc !== 1'b1) $display("FAIL down_tc: tc=%0b expected 1", s_tc); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (s_count !== 4'd0) $display("FAIL down_sat_hold: count=%0d expected 0", s_count); else n_pass++;
      n_checks++; if (s_wrap !== 1'b0) $display("FAIL down_sat_wrap: wrap=%0b expected 0", s_wrap); else n_pass++;
      if (i == 0) begin
        n_checks++; if (w_count !== 4'd9 || w_wrap !== 1'b1)
          $display("FAIL down_wrap: count=%0d wrap=%0b expected 9/1", w_count, w_wrap); else n_pass++;
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_r [3];
    exp_r[0] = 4'b0011; exp_r[1] = 4'b0110; exp_r[2] = 4'b0011;
    load = 1'b1; lv = 8'b0000_1001;
    tick();
    load = 1'b0; mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mode = 2'd3;
      #1;
      n_checks++; if (w_tc !== 1'b0) $display("FAIL rot_tc: tc=%0b expected 0", w_tc); else n_pass++;
      tick();
      n_checks++; if (w_count !== exp_r[i]) $display("FAIL rot_step%0d: count=%b expected %b", i, w_count, exp_r[i]); else n_pass++;
    end
    mode = 2'd0;
    tick();
    n_checks++; if (w_count !== 4'b0100) $display("FAIL rot_to_up: count=%b expected 0100", w_count); else n_pass++;
  endtask

  task automatic test_priority();
    set = 1'b1; load = 1'b1; en = 1'b1; lv = 8'd3; mode = 2'd0;
    tick();
    n_checks++; if (w_count !== 4'd9) $display("FAIL prio_set: count=%0d expected 9", w_count); else n_pass++;
    set = 1'b0; lv = 8'd12;
    tick();
    n_checks++; if (w_count !== 4'd12) $display("FAIL prio_load: count=%0d expected 12", w_count); else n_pass++;
    load = 1'b0;
    tick();
    n_checks++; if (w_count !== 4'd0 || w_wrap !== 1'b1)
      $display("FAIL prio_above_max: count=%0d wrap=%0b expected 0/1", w_count, w_wrap); else n_pass++;
    n_checks++; if (s_count !== 4'd12 || s_wrap !== 1'b0)
      $display("FAIL prio_sat_above_max: count=%0d wrap=%0b expected 12/0", s_count, s_wrap); else n_pass++;
  endtask

  task automatic test_enable();
    set = 1'b1;
    tick();
    set = 1'b0; en = 1'b0; mode = 2'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (d_count !== 8'd255) $display("FAIL en_hold: count=%0d expected 255", d_count); else n_pass++;
      n_checks++; if (d_tc !== 1'b0) $display("FAIL en_hold_tc: tc=%0b expected 0", d_tc); else n_pass++;
    end
    en = 1'b1; #1;
    n_checks++; if (d_tc !== 1'b1) $display("FAIL en_tc: tc=%0b expected 1", d_tc); else n_pass++;
    tick();
    n_checks++; if (d_count !== 8'd0 || d_wrap !== 1'b1)
      $display("FAIL en_wrap: count=%0d wrap=%0b expected 0/1", d_count, d_wrap); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set  = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      lv   = 8'($urandom_range(0, 255));
      #1;
      n_checks++; if (w_tc !== model_tc(mw, 9)) $display("FAIL rnd_tc_w: tc=%0b expected %0b", w_tc, model_tc(mw, 9)); else n_pass++;
      n_checks++; if (s_tc !== model_tc(ms, 9)) $display("FAIL rnd_tc_s: tc=%0b expected %0b", s_tc, model_tc(ms, 9)); else n_pass++;
      n_checks++; if (d_tc !== model_tc(md, 255)) $display("FAIL rnd_tc_d: tc=%0b expected %0b", d_tc, model_tc(md, 255)); else n_pass++;
      tick();
      n_checks++; if (w_count !== 4'(mw) || w_wrap !== mww)
        $display("FAIL rnd_w: count=%0d wrap=%0b expected %0d/%0b", w_count, w_wrap, mw, mww); else n_pass++;
      n_checks++; if (s_count !== 4'(ms) || s_wrap !== mws)
        $display("FAIL rnd_s: count=%0d wrap=%0b expected %0d/%0b", s_count, s_wrap, ms, mws); else n_pass++;
      n_checks++; if (d_count !== 8'(md) || d_wrap !== mwd)
        $display("FAIL rnd_d: count=%0d wrap=%0b expected %0d/%0b", d_count, d_wrap, md, mwd); else n_pass++;
    end
    set = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_up_wrap();
    test_down_sat();
    test_rotate();
    test_priority();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
